// File: rtl/div_scheduler.sv
// rtl/div_scheduler.sv - round-robin scheduler sharing one iterative divider between two requesters
// Define SIGNED_DIV_EN for two's-complement operands with sign fix-up at capture.
module div_scheduler #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_q,
    output logic [WIDTH-1:0] resp_r,
    output logic             resp_divzero,
    output logic             div_start,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    localparam int CW = $clog2(ITER + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ZERO,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_id;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_resp_q;
    logic [WIDTH-1:0] r_resp_r;
    logic             r_resp_id;
    logic             r_resp_divzero;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [WIDTH-1:0] w_cap_q;
    logic [WIDTH-1:0] w_cap_r;

    // On a tie the requester that did not win last time is granted.
    assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

    assign req0_ready = (r_state == S_IDLE) && w_grant0;
    assign req1_ready = (r_state == S_IDLE) && w_grant1;

    assign w_acc0   = req0_valid && req0_ready;
    assign w_acc1   = req1_valid && req1_ready;
    assign w_accept = w_acc0 || w_acc1;
    assign w_sel_a  = w_acc1 ? req1_a : req0_a;
    assign w_sel_b  = w_acc1 ? req1_b : req0_b;

`ifdef SIGNED_DIV_EN
    // Magnitudes go to the divider; |MIN| wraps to MIN, which reads correctly as unsigned.
    assign div_a   = r_a[WIDTH-1] ? (~r_a + 1'b1) : r_a;
    assign div_b   = r_b[WIDTH-1] ? (~r_b + 1'b1) : r_b;
    assign w_cap_q = (r_a[WIDTH-1] ^ r_b[WIDTH-1]) ? (~div_q + 1'b1) : div_q;
    assign w_cap_r = r_a[WIDTH-1] ? (~div_r + 1'b1) : div_r;
`else
    assign div_a   = r_a;
    assign div_b   = r_b;
    assign w_cap_q = div_q;
    assign w_cap_r = div_r;
`endif

    assign div_start    = (r_state == S_LAUNCH);
    assign resp_valid   = (r_state == S_DONE);
    assign resp_id      = r_resp_id;
    assign resp_q       = r_resp_q;
    assign resp_r       = r_resp_r;
    assign resp_divzero = r_resp_divzero;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = (w_sel_b == '0) ? S_ZERO : S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT: begin
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end
            end
            S_ZERO:  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_last_grant   <= 1'b1;
            r_a            <= '0;
            r_b            <= '0;
            r_id           <= 1'b0;
            r_cnt          <= '0;
            r_resp_q       <= '0;
            r_resp_r       <= '0;
            r_resp_id      <= 1'b0;
            r_resp_divzero <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_a          <= w_sel_a;
                r_b          <= w_sel_b;
                r_id         <= w_acc1;
                r_last_grant <= w_acc1;
            end
            case (r_state)
                S_LAUNCH: r_cnt <= CW'(ITER);
                S_WAIT: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_resp_q       <= w_cap_q;
                        r_resp_r       <= w_cap_r;
                        r_resp_id      <= r_id;
                        r_resp_divzero <= 1'b0;
                    end
                end
                S_ZERO: begin
                    r_resp_q       <= '1;
                    r_resp_r       <= r_a;
                    r_resp_id      <= r_id;
                    r_resp_divzero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_scheduler.sv
// tb/tb_div_scheduler.sv - scoreboard bench for div_scheduler with a behavioural divider model
module tb_div_scheduler;

    localparam int W    = 32;
    localparam int ITER = 32;

    typedef struct packed {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } resp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_id, resp_divzero, div_start;
    logic [W-1:0] resp_q, resp_r, div_a, div_b;
    logic [W-1:0] div_q = '0, div_r = '0;

    resp_t sb[$];
    resp_t obs[$];
    op_t   q0[$];
    op_t   q1[$];
    int    resp_cyc[$];
    int    acc_id[$];
    int    acc_cyc[$];
    int    n_start, n_both;
    int    vectors = 0;
    int    miscompares = 0;

    div_scheduler #(.WIDTH(W), .ITER(ITER)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_q(resp_q), .resp_r(resp_r),
        .resp_divzero(resp_divzero), .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r)
    );

    always #5 clock = ~clock;

    // Iterative divider stand-in: garbage until the result becomes valid near the end of its run.
    int           m_cnt = 0;
    logic [W-1:0] m_a = '0, m_b = '1;
    always @(posedge clock) begin
        if (div_start) begin
            m_a   <= div_a;
            m_b   <= div_b;
            m_cnt <= ITER;
            div_q <= 32'hDEAD_BEEF;
            div_r <= 32'hBADC_0FFE;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                div_q <= m_a / m_b;
                div_r <= m_a % m_b;
            end
        end
    end

    function automatic resp_t expect_of(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        resp_t e;
        e.id = id;
        if (b == '0) begin
            e.q = '1; e.r = a; e.dz = 1'b1;
        end else begin
            e.dz = 1'b0;
`ifdef SIGNED_DIV_EN
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.q = 32'h8000_0000; e.r = '0;
            end else begin
                e.q = W'($signed(a) / $signed(b));
                e.r = W'($signed(a) % $signed(b));
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Drives queued operations and records accepts, responses and strobes until n_resp results appear.
    task automatic run(input int n_resp, input int max_cyc, output bit to);
        bit a0 = 1'b0, a1 = 1'b0;
        to = 1'b0;
        obs.delete(); resp_cyc.delete(); acc_id.delete(); acc_cyc.delete();
        n_start = 0; n_both = 0;
        for (int cyc = 0; ; cyc++) begin
            @(negedge clock);
            if (a0) void'(q0.pop_front());
            if (a1) void'(q1.pop_front());
            req0_valid = (q0.size() != 0);
            if (req0_valid) begin req0_a = q0[0].a; req0_b = q0[0].b; end
            req1_valid = (q1.size() != 0);
            if (req1_valid) begin req1_a = q1[0].a; req1_b = q1[0].b; end
            #1;
            if (req0_ready && req1_ready) n_both++;
            if (div_start) n_start++;
            if (resp_valid) begin
                obs.push_back('{resp_id, resp_q, resp_r, resp_divzero});
                resp_cyc.push_back(cyc);
            end
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            if (a0) begin acc_id.push_back(0); acc_cyc.push_back(cyc); end
            if (a1) begin acc_id.push_back(1); acc_cyc.push_back(cyc); end
            if (obs.size() >= n_resp) break;
            if (cyc >= max_cyc) begin to = 1'b1; break; end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if ({resp_valid, resp_id, resp_divzero, div_start, req0_ready, req1_ready} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {resp_valid, resp_id, resp_divzero, div_start, req0_ready, req1_ready});
        end
        vectors++;
        if ({resp_q, resp_r, div_a, div_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got q=%h r=%h da=%h db=%h expected all 0", resp_q, resp_r, div_a, div_b);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        bit to;
        resp_t e;
        sb.delete();
        q0.push_back('{32'd26, 32'd2});
        sb.push_back('{1'b0, 32'd13, 32'd0, 1'b0});
        run(1, 100, to);
        vectors++;
        if (to || obs.size() < 1 || acc_cyc.size() < 1) begin
            miscompares++;
            $display("FAIL single_timeout: got %0d responses expected 1", obs.size());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (obs[0] !== e) begin
            miscompares++;
            $display("FAIL single_resp: got %h expected %h", obs[0], e);
        end
        vectors++;
        if (acc_cyc[0] !== 0) begin
            miscompares++;
            $display("FAIL single_ready_cycle: got %0d expected 0", acc_cyc[0]);
        end
        vectors++;
        if (resp_cyc[0] - acc_cyc[0] !== ITER + 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d expected %0d", resp_cyc[0] - acc_cyc[0], ITER + 2);
        end
        vectors++;
        if (n_start !== 1) begin
            miscompares++;
            $display("FAIL single_start_pulses: got %0d expected 1", n_start);
        end
        @(negedge clock);
        vectors++;
        if ({resp_valid, resp_q} !== {1'b0, 32'd13}) begin
            miscompares++;
            $display("FAIL single_hold: got valid=%b q=%h expected valid=0 q=0000000d", resp_valid, resp_q);
        end
    endtask

    task automatic test_divzero();
        bit to;
        resp_t e;
        sb.delete();
        q1.push_back('{32'd5, 32'd0});
        sb.push_back('{1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1});
        run(1, 50, to);
        vectors++;
        if (to || obs.size() < 1 || acc_cyc.size() < 1) begin
            miscompares++;
            $display("FAIL divzero_timeout: got %0d responses expected 1", obs.size());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (obs[0] !== e) begin
            miscompares++;
            $display("FAIL divzero_resp: got %h expected %h", obs[0], e);
        end
        vectors++;
        if (resp_cyc[0] - acc_cyc[0] !== 2) begin
            miscompares++;
            $display("FAIL divzero_latency: got %0d expected 2", resp_cyc[0] - acc_cyc[0]);
        end
        vectors++;
        if (n_start !== 0) begin
            miscompares++;
            $display("FAIL divzero_start: got %0d pulses expected 0", n_start);
        end
    endtask

    task automatic test_arbitration();
        bit to;
        resp_t e;
        sb.delete();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        q0.push_back('{32'd252, 32'd3});
        q1.push_back('{32'd254, 32'd3});
        sb.push_back('{1'b0, 32'd84, 32'd0, 1'b0});
        sb.push_back('{1'b1, 32'd84, 32'd2, 1'b0});
        run(2, 200, to);
        vectors++;
        if (to || obs.size() < 2 || acc_id.size() < 2) begin
            miscompares++;
            $display("FAIL arb_timeout: got %0d responses expected 2", obs.size());
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            vectors++;
            if (obs[i] !== e) begin
                miscompares++;
                $display("FAIL arb_resp%0d: got %h expected %h", i, obs[i], e);
            end
        end
        vectors++;
        if ({acc_id[0], acc_id[1]} !== {0, 1}) begin
            miscompares++;
            $display("FAIL arb_order: got %0d,%0d expected 0,1", acc_id[0], acc_id[1]);
        end
        vectors++;
        if (acc_cyc[1] !== resp_cyc[0] + 1) begin
            miscompares++;
            $display("FAIL arb_second_accept: got cycle %0d expected %0d", acc_cyc[1], resp_cyc[0] + 1);
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        resp_t e;
        op_t o0[2] = '{'{32'd1000, 32'd7}, '{32'd123456789, 32'd1000}};
        op_t o1[2] = '{'{32'hFFFF_FFFF, 32'd16}, '{32'd7, 32'd9}};
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            q0.push_back(o0[i]);
            q1.push_back(o1[i]);
            sb.push_back(expect_of(1'b0, o0[i].a, o0[i].b));
            sb.push_back(expect_of(1'b1, o1[i].a, o1[i].b));
        end
        run(4, 400, to);
        vectors++;
        if (to || obs.size() < 4 || acc_id.size() < 4) begin
            miscompares++;
            $display("FAIL b2b_timeout: got %0d responses expected 4", obs.size());
            return;
        end
        for (int i = 0; i < 4; i++) begin
            e = sb.pop_front();
            vectors++;
            if (obs[i] !== e || acc_id[i] !== (i % 2)) begin
                miscompares++;
                $display("FAIL b2b_op%0d: got grant=%0d resp=%h expected grant=%0d resp=%h",
                         i, acc_id[i], obs[i], i % 2, e);
            end
        end
        for (int i = 1; i < 4; i++) begin
            vectors++;
            if (acc_cyc[i] !== resp_cyc[i-1] + 1) begin
                miscompares++;
                $display("FAIL b2b_gap%0d: got accept %0d expected %0d", i, acc_cyc[i], resp_cyc[i-1] + 1);
            end
        end
        vectors++;
        if (n_both !== 0) begin
            miscompares++;
            $display("FAIL b2b_dual_ready: got %0d cycles expected 0", n_both);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int spurious = 0;
        resp_t e;
        sb.delete();
        @(negedge clock);
        req0_valid = 1'b1; req0_a = 32'd1000; req0_b = 32'd3;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_accept: got ready=%b expected 1", req0_ready);
        end
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            req0_valid = 1'b0;
        end
        reset = 1'b1;
        @(negedge clock);
        #1;
        vectors++;
        if ({resp_valid, resp_id, resp_divzero, div_start, req0_ready, req1_ready,
             resp_q, resp_r, div_a, div_b} !== '0) begin
            miscompares++;
            $display("FAIL rmid_outputs: got v=%b id=%b dz=%b st=%b q=%h r=%h da=%h db=%h expected all 0",
                     resp_valid, resp_id, resp_divzero, div_start, resp_q, resp_r, div_a, div_b);
        end
        reset = 1'b0;
        repeat (60) begin
            @(negedge clock);
            if (resp_valid) spurious++;
        end
        vectors++;
        if (spurious !== 0) begin
            miscompares++;
            $display("FAIL rmid_no_resp: got %0d strobes expected 0", spurious);
        end
        q0.push_back('{32'd100, 32'd7});
        sb.push_back('{1'b0, 32'd14, 32'd2, 1'b0});
        run(1, 100, to);
        vectors++;
        if (to || obs.size() < 1) begin
            miscompares++;
            $display("FAIL rmid_timeout: got %0d responses expected 1", obs.size());
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (obs[0] !== e) begin
            miscompares++;
            $display("FAIL rmid_resp: got %h expected %h", obs[0], e);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        bit to;
        resp_t e;
        sb.delete();
        q0.push_back('{32'hFFFF_FFF9, 32'd2});
        q0.push_back('{32'h8000_0000, 32'hFFFF_FFFF});
        sb.push_back('{1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
        sb.push_back('{1'b0, 32'h8000_0000, 32'h0, 1'b0});
        run(2, 200, to);
        vectors++;
        if (to || obs.size() < 2) begin
            miscompares++;
            $display("FAIL signed_timeout: got %0d responses expected 2", obs.size());
            return;
        end
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            vectors++;
            if (obs[i] !== e) begin
                miscompares++;
                $display("FAIL signed_resp%0d: got %h expected %h", i, obs[i], e);
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_divzero();
        test_arbitration();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/div_scheduler.md
Name: div_scheduler

Overview:
- Shares one iterative `Division` unit (start/clock/a/b/q/r, 32-cycle latency) between two requesters.
- Round-robin arbitration; operands latched on accept.
- Sequences the divider's start pulse and counts the iteration cycles.
- Returns quotient/remainder on a shared response bus tagged with requester id; divide-by-zero is handled without using the divider.

Parameters:
- WIDTH, 32, operand/result width.
- ITER, 32, clock cycles `Division` needs after its start pulse before q/r are valid.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_a  in  WIDTH  dividend 0
- req0_b  in  WIDTH  divisor 0
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 accepted this cycle
- req1_a  in  WIDTH  dividend 1
- req1_b  in  WIDTH  divisor 1
- resp_valid  out  1  one-cycle result strobe
- resp_id  out  1  requester that owns the result
- resp_q  out  WIDTH  quotient
- resp_r  out  WIDTH  remainder
- resp_divzero  out  1  divisor was zero
- div_start  out  1  start pulse to `Division`
- div_a  out  WIDTH  dividend to `Division`
- div_b  out  WIDTH  divisor to `Division`
- div_q  in  WIDTH  quotient from `Division`
- div_r  in  WIDTH  remainder from `Division`

Behaviour:
- Reset values:
  - All outputs 0, state IDLE, cycle counter 0.
  - last_grant=1, so req0 wins the first tie.
- Reset mid-operation: aborts at the next edge and no response is issued. `Division` has no reset; its stale result is ignored and the next div_start reinitialises it.
- Handshake:
  - reqN_ready is combinational and high only in IDLE for the granted requester.
  - Transfer occurs when valid&&ready at a rising edge.
  - Requesters hold a/b stable while valid and not ready.
  - At most one ready is high per cycle.
- Arbitration:
  - Only one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - last_grant updates on accept.
- Accept action: latch a, b and id into internal registers.
- State machine:
  - IDLE: go to LAUNCH on accept with b!=0, or to ZERO on accept with b==0.
  - LAUNCH: one cycle; div_start=1, div_a/div_b driven from the latches, counter loaded with ITER; go to WAIT.
  - WAIT: div_start=0 and div_a/div_b held constant; counter decrements each cycle; when it reaches 1, capture div_q/div_r into resp_q/resp_r and go to DONE.
  - ZERO: one cycle; set resp_q = all ones and resp_r = latched a; go to DONE. div_start is never asserted for this operation.
  - DONE: resp_valid=1 for exactly one cycle with resp_id and resp_divzero; go to IDLE.
- resp_q, resp_r, resp_id and resp_divzero hold their value until the next DONE; resp_valid is the only strobe.
- Latency (accept edge = cycle 0):
  - Nonzero divisor: resp_valid high in cycle ITER+2.
  - Zero divisor: resp_valid high in cycle 2.
- Next accept is possible at the earliest in the cycle after resp_valid.
- Requests arriving while busy are not accepted and wait, with no loss.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined: operands are two's-complement signed.
  - div_a = |a|, div_b = |b|.
  - Quotient is negated if sign(a)!=sign(b).
  - Remainder takes the sign of a.
  - -2^(WIDTH-1) / -1 gives q=0x80000000, r=0.
  - Divide-by-zero gives q=all ones, r=a (unchanged).
  - Sign fix-up is applied at the WAIT→DONE capture, so latency is unchanged.
- Undefined: unsigned only, and div_a/div_b are the raw latched operands.

Test Plan:
- req0 26/2 alone → req0_ready at cycle 0; resp_valid at cycle 34 (ITER=32) with id=0, q=13, r=0, divzero=0; div_start high exactly one cycle.
- req0 252/3 and req1 254/3 asserted in the same cycle after reset → req0 served first (q=84, r=0); req1 accepted in the cycle after req0's resp_valid (q=84, r=2, id=1).
- Both requesters held valid continuously for 4 operations → grants alternate 0,1,0,1; no starvation; ready is never high for both at once.
- req1 5/0 → resp_valid at cycle 2 with q=0xFFFFFFFF, r=5, divzero=1; div_start stays 0.
- reset asserted in WAIT at cycle 10 → no resp_valid; all outputs 0 next cycle; a following req0 100/7 returns q=14, r=2.
- With SIGNED_DIV_EN: -7/2 → q=-3 (0xFFFFFFFD), r=-1; 0x80000000/-1 → q=0x80000000, r=0.
